instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the single-cycle datapath.
- Holds the PC and fetches 16-bit instructions from an instruction memory over a req/ack handshake with variable latency.
- Buffers fetched words in a small prefetch FIFO and presents them to the datapath as `in_instruction` / `ready`.
- Accepts PC redirects (branch/jump) from the controller and flushes stale instructions.

---
 rtl/instr_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the single-cycle datapath.
//
// Holds the fetch PC, issues one outstanding request at a time to the instruction memory
// over a req/ack handshake of variable latency, and buffers returned words in a small
// prefetch FIFO. PC redirects flush the FIFO; an in-flight request at redirect time is
// completed and its data dropped (DRAIN state).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_req/addr      fetch request and address (registered, held until imem_ack)
//   imem_ack/rdata     memory response
//   in_instruction     FIFO head word (combinational, 0 when empty)
//   ready              FIFO not empty (combinational)
//   advance            datapath consumes the head word
//   redirect/_pc       one-cycle PC redirect pulse and target
//   halt               level, blocks new requests only
//   pc_out             address of the head word, or fetch PC when empty (registered)
//
// Optional: define IFU_PERF_COUNTERS_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        DATA_W     = 16,
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] in_instruction,
    output logic              ready,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
`ifdef IFU_PERF_COUNTERS_EN
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt,
`endif
    output logic [ADDR_W-1:0] pc_out
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
    logic [CNT_W-1:0]  count_q, count_d, count_after;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic push, pop, space;

    assign ready          = (count_q != '0);
    assign in_instruction = ready ? data_mem[rd_ptr_q] : '0;
    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign pc_out         = pc_out_q;

    // Redirect wins over both a returning word and a consume in the same cycle.
    assign push        = (state_q == StWait) && imem_ack && !redirect;
    assign pop         = advance && ready && !redirect;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    assign space       = (count_after < DEPTH_C);
    assign rd_next     = rd_ptr_q + 1'b1;

    // Fetch FSM and PC.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        if (push) fetch_pc_d = fetch_pc_q + 1'b1;
        if (redirect) fetch_pc_d = redirect_pc;
        unique case (state_q)
            StIdle: begin
                if (!halt && !redirect && (count_q < DEPTH_C)) begin
                    state_d = StWait;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            StWait: begin
                if (imem_ack) begin
                    if (!redirect && !halt && space) begin
                        // Back-to-back: keep req high with the next address.
                        req_d  = 1'b1;
                        addr_d = fetch_pc_d;
                    end else begin
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    // Request must still complete; its data is dropped in DRAIN.
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (imem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // FIFO pointers and the registered head-PC.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_next;
            count_d = count_after;
        end

        // Predict the head entry after this edge so pc_out can be a register.
        if (count_d == '0) begin
            pc_out_d = fetch_pc_d;
        end else if (pop) begin
            pc_out_d = (count_q > CNT_W'(1)) ? pc_mem[rd_next] : addr_q;
        end else begin
            pc_out_d = (count_q == '0) ? addr_q : pc_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pc_out_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_out_q   <= pc_out_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (!ready && !halt && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a behavioural memory (configurable latency) pushes expected
// {pc, word} entries to a scoreboard queue on each accepted ack; consumed words are popped
// and compared. Table-driven reset-to-steady-state runs plus hand sequences for redirect,
// halt, wrap and reset-mid-request.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] in_instruction;
    logic        ready;
    logic        advance = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        halt = 1'b0;
    logic [7:0]  pc_out;
`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(2), .RESET_PC(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .in_instruction(in_instruction), .ready(ready),
        .advance(advance), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt),
`ifdef IFU_PERF_COUNTERS_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [7:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] data;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] acc_addrs[$];
    int         mem_lat = 0;
    bit         spur_ack = 1'b0;
    int         ack_cnt = 0;
    int         wait_cnt = 0;
    bit         stale = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_addr = '0;
    logic [7:0] exp_addr = '0;

    // Memory model and scoreboard; runs on the falling edge, stimulus changes at posedge+2.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ack   = spur_ack;
            imem_rdata = 16'hDEAD;
            exp_q.delete();
            acc_addrs.delete();
            ack_cnt  = 0;
            wait_cnt = 0;
            stale    = 1'b0;
            pend     = 1'b0;
            exp_addr = 8'h00;
        end else begin
            if (ready && advance && !redirect) begin
                if (exp_q.size() == 0) begin
                    chk("underflow", 32'(ready), 32'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("consume_data", 32'(in_instruction), 32'(e.data));
                    chk("consume_pc", 32'(pc_out), 32'(e.pc));
                end
            end
            if (pend) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", 32'(imem_addr), 32'(pend_addr));
            end
            if (redirect) begin
                exp_q.delete();
                acc_addrs.delete();
                exp_addr = redirect_pc;
            end
            imem_ack = 1'b0;
            if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(imem_addr);
                    ack_cnt++;
                    wait_cnt = 0;
                    pend     = 1'b0;
                    if (!stale && !redirect) begin
                        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
                        exp_addr = exp_addr + 8'd1;
                        exp_q.push_back({imem_addr, word_of(imem_addr)});
                        acc_addrs.push_back(imem_addr);
                    end
                    stale = 1'b0;
                end else begin
                    wait_cnt++;
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    if (redirect) stale = 1'b1;
                end
            end else begin
                wait_cnt = 0;
                pend     = 1'b0;
                if (spur_ack) begin
                    imem_ack   = 1'b1;
                    imem_rdata = 16'hBEEF;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_run(input int lat, input bit adv, input bit hlt);
        rst_n = 1'b0; advance = 1'b0; halt = 1'b0; redirect = 1'b0;
        step(2);
        mem_lat = lat; advance = adv; halt = hlt;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         lat;
        bit         adv;
        bit         hlt;
        int         cycles;
        int         exp_acks;
        bit         exp_req;
        bit         exp_ready;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs[5];

    initial begin #200000; $display("FAIL watchdog: time limit reached"); $fatal; end

    initial begin
        int n;
        vecs[0] = '{lat: 0, adv: 1, hlt: 0, cycles: 20, exp_acks: 19, exp_req: 1,
                    exp_ready: 1, exp_pc: 8'h12};
        vecs[1] = '{lat: 0, adv: 0, hlt: 0, cycles: 20, exp_acks: 2, exp_req: 0,
                    exp_ready: 1, exp_pc: 8'h00};
        vecs[2] = '{lat: 3, adv: 0, hlt: 0, cycles: 20, exp_acks: 2, exp_req: 0,
                    exp_ready: 1, exp_pc: 8'h00};
        vecs[3] = '{lat: 3, adv: 1, hlt: 0, cycles: 20, exp_acks: 4, exp_req: 1,
                    exp_ready: 0, exp_pc: 8'h04};
        vecs[4] = '{lat: 2, adv: 0, hlt: 1, cycles: 20, exp_acks: 0, exp_req: 0,
                    exp_ready: 0, exp_pc: 8'h00};

        // Reset state.
        step(2);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_instr", 32'(in_instruction), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);

        foreach (vecs[i]) begin
            start_run(vecs[i].lat, vecs[i].adv, vecs[i].hlt);
            step(vecs[i].cycles);
            chk($sformatf("vec%0d_acks", i), 32'(ack_cnt), 32'(vecs[i].exp_acks));
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].exp_pc));
        end

        // Full FIFO with latency 3, one advance releases exactly one more fetch at 0x02.
        start_run(3, 1'b0, 1'b0);
        step(20);
        chk("fill_acks", 32'(ack_cnt), 32'd2);
        advance = 1'b1;
        step(1);
        advance = 1'b0;
        step(12);
        chk("adv1_acks", 32'(ack_cnt), 32'd3);
        chk("adv1_req", 32'(imem_req), 32'd0);
        chk("adv1_n", 32'(acc_addrs.size()), 32'd3);
        if (acc_addrs.size() >= 3) chk("adv1_addr", 32'(acc_addrs[2]), 32'h02);

        // Redirect to 0x40 while the 0x05 request is outstanding.
        start_run(3, 1'b1, 1'b0);
        n = 0;
        while (!(imem_req && imem_addr == 8'h05) && n < 100) begin step(1); n++; end
        chk("wait_req5", 32'(n < 100), 32'd1);
        redirect = 1'b1; redirect_pc = 8'h40;
        step(1);
        redirect = 1'b0;
        chk("rd_ready", 32'(ready), 32'd0);
        chk("rd_pc_out", 32'(pc_out), 32'h40);
        chk("rd_drain_addr", 32'(imem_addr), 32'h05);
        n = 0;
        while (!ready && n < 100) begin step(1); n++; end
        chk("wait_ready40", 32'(n < 100), 32'd1);
        chk("rd_head_pc", 32'(pc_out), 32'h40);
        chk("rd_head_data", 32'(in_instruction), 32'(word_of(8'h40)));

        // Redirect coincident with ack and advance; target 0xFE also exercises wrap.
        start_run(0, 1'b1, 1'b0);
        step(6);
        redirect = 1'b1; redirect_pc = 8'hFE;
        step(1);
        redirect = 1'b0;
        chk("rda_req", 32'(imem_req), 32'd0);
        chk("rda_ready", 32'(ready), 32'd0);
        chk("rda_pc_out", 32'(pc_out), 32'hFE);
        step(1);
        chk("rda_req2", 32'(imem_req), 32'd1);
        chk("rda_addr2", 32'(imem_addr), 32'hFE);
        step(6);
        chk("wrap_n", 32'(acc_addrs.size() >= 3), 32'd1);
        if (acc_addrs.size() >= 3) begin
            chk("wrap_a0", 32'(acc_addrs[0]), 32'hFE);
            chk("wrap_a1", 32'(acc_addrs[1]), 32'hFF);
            chk("wrap_a2", 32'(acc_addrs[2]), 32'h00);
        end

        // halt with a request in flight: it completes and is buffered, nothing new issues.
        start_run(3, 1'b0, 1'b0);
        step(2);
        halt = 1'b1;
        step(15);
        chk("halt_acks", 32'(ack_cnt), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_ready", 32'(ready), 32'd1);
        chk("halt_data", 32'(in_instruction), 32'(word_of(8'h00)));
        halt = 1'b0;
        step(2);
        chk("unhalt_req", 32'(imem_req), 32'd1);
        chk("unhalt_addr", 32'(imem_addr), 32'h01);

        // Reset mid-request: outputs drop at once, a late ack is ignored.
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_pc_out", 32'(pc_out), 32'd0);
        spur_ack = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        spur_ack = 1'b0;
        chk("late_ack_ready", 32'(ready), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_addr", 32'(imem_addr), 32'h00);
        step(10);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_data", 32'(in_instruction), 32'(word_of(8'h00)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
